// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing generator: walks the pixel grid, produces de/hsync/vsync,
// and forwards upstream pixels to the TMDS encoders with one register of latency.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clkin,
  input  logic        rstin,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  input  logic        clr_underflow,
  output logic        pix_ready,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        frame_start,
  output logic        underflow,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_chk
      $error("dvi_timing_ctrl: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end
  endgenerate

  // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST    = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST    = 13'(V_TOTAL - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] STOP_PEND = 2'd2;

  logic [1:0]  state;
  logic [12:0] h_ext, v_ext;
  logic        running, active, h_last, v_last, hs_win, vs_win;

  logic        de_p1, hsync_p1, vsync_p1, fs_p1, uf_p1;
  logic [23:0] rgb_p1;

  assign h_ext   = {1'b0, h_cnt};
  assign v_ext   = {1'b0, v_cnt};
  assign running = (state != IDLE);
  assign h_last  = (h_ext == H_LAST);
  assign v_last  = (v_ext == V_LAST);
  assign active  = running && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign hs_win  = running && (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs_win  = running && (v_ext >= VS_BEG) && (v_ext < VS_END);

  assign pix_ready = active;
  assign busy      = running;

  // Stage p0: control FSM and raster counters
  always_ff @(posedge clkin) begin
    if (rstin) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      unique case (state)
        IDLE:      if (en) state <= RUN;
        RUN:       if (!en) state <= STOP_PEND;
        STOP_PEND: begin
          if (en)                  state <= RUN;
          else if (h_last && v_last) state <= IDLE;
        end
        default:   state <= IDLE;
      endcase
      // Counters hold at (0,0) in IDLE; a frame end wraps them back there anyway
      if (running) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
        end else begin
          h_cnt <= h_cnt + 12'd1;
        end
      end
    end
  end

  // Stage p1: registered encoder-side outputs
  always_ff @(posedge clkin) begin
    if (rstin) begin
      de_p1    <= 1'b0;
      hsync_p1 <= ~HS_POL;
      vsync_p1 <= ~VS_POL;
      fs_p1    <= 1'b0;
      uf_p1    <= 1'b0;
      rgb_p1   <= '0;
    end else begin
      de_p1    <= active;
      hsync_p1 <= hs_win ? HS_POL : ~HS_POL;
      vsync_p1 <= vs_win ? VS_POL : ~VS_POL;
      fs_p1    <= running && (h_cnt == 12'd0) && (v_cnt == 12'd0);
      rgb_p1   <= (active && pix_valid) ? pix_data : 24'd0;
      if (active && !pix_valid) uf_p1 <= 1'b1;
      else if (clr_underflow)   uf_p1 <= 1'b0;
    end
  end

  assign de          = de_p1;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign frame_start = fs_p1;
  assign underflow   = uf_p1;
  assign red         = rgb_p1[23:16];
  assign green       = rgb_p1[15:8];
  assign blue        = rgb_p1[7:0];

endmodule
